// File: rtl/score_display_scan.sv
// rtl/score_display_scan.sv - two-digit seven-segment scanner with blanking, leading-zero suppression and blink
module score_display_scan #(
  parameter int BLANK_CYCLES = 500,
  parameter int SHOW_CYCLES  = 49500,
  parameter int BLINK_DIV    = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       blink,
  input  logic [3:0] displayNum,
  output logic [1:0] digit,
  output logic [6:0] seg,
  output logic [1:0] digitEn,
  output logic       frameDone
);

  localparam int CMAX = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(BLINK_DIV + 1);

  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST   = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_PENULT = CW'(SHOW_CYCLES - 2);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    DARK        = 7'h7F;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          phase_nxt;
  logic          cur;
  logic [3:0]    nib;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40;
      4'h1: enc = 7'h79;
      4'h2: enc = 7'h24;
      4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;
      4'h5: enc = 7'h12;
      4'h6: enc = 7'h02;
      4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;
      4'h9: enc = 7'h10;
      4'hA: enc = 7'h08;
      4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;
      4'hD: enc = 7'h21;
      4'hE: enc = 7'h06;
      default: enc = 7'h0E;
    endcase
  endfunction

  // Segment pattern while a digit is lit: tens zero and blink-off phase go dark
  function automatic logic [6:0] lit(input logic [3:0] n, input logic tens,
                                     input logic blk, input logic ph);
    if ((tens && n == 4'd0) || (blk && !ph)) lit = DARK;
    else lit = enc(n);
  endfunction

  assign digit     = {1'b0, cur};
  // Phase as it will be after this edge, so registered segments line up with it
  assign phase_nxt = (bcnt == BLINK_LAST) ? ~phase : phase;

  // Blink divider: free-runs only while the display is enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (enable) begin
      if (bcnt == BLINK_LAST) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Scan FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur       <= 1'b0;
      nib       <= 4'd0;
      seg       <= DARK;
      digitEn   <= 2'b11;
      frameDone <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      cnt       <= '0;
      cur       <= 1'b0;
      seg       <= DARK;
      digitEn   <= 2'b11;
      frameDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= BLANK;
          cnt       <= '0;
          cur       <= 1'b0;
          seg       <= DARK;
          digitEn   <= 2'b11;
          frameDone <= 1'b0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state     <= SHOW;
            cnt       <= '0;
            nib       <= displayNum;
            seg       <= lit(displayNum, cur, blink, phase_nxt);
            digitEn   <= cur ? 2'b01 : 2'b10;
            frameDone <= cur && (SHOW_CYCLES == 1);
          end else begin
            cnt       <= cnt + 1'b1;
            seg       <= DARK;
            digitEn   <= 2'b11;
            frameDone <= 1'b0;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state     <= BLANK;
            cnt       <= '0;
            cur       <= ~cur;
            seg       <= DARK;
            digitEn   <= 2'b11;
            frameDone <= 1'b0;
          end else begin
            cnt       <= cnt + 1'b1;
            seg       <= lit(nib, cur, blink, phase_nxt);
            digitEn   <= cur ? 2'b01 : 2'b10;
            frameDone <= cur && (cnt == SHOW_PENULT);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          cur       <= 1'b0;
          seg       <= DARK;
          digitEn   <= 2'b11;
          frameDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_display_scan.sv
// tb/tb_score_display_scan.sv - directed self-checking bench for score_display_scan
module tb_score_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       blink;
  logic [3:0] displayNum;
  logic [1:0] digit;
  logic [6:0] seg;
  logic [1:0] digitEn;
  logic       frameDone;

  logic [3:0] ones;
  logic [3:0] tens;

  int checks   = 0;
  int failures = 0;

  score_display_scan #(
    .BLANK_CYCLES(2),
    .SHOW_CYCLES (4),
    .BLINK_DIV   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .blink     (blink),
    .displayNum(displayNum),
    .digit     (digit),
    .seg       (seg),
    .digitEn   (digitEn),
    .frameDone (frameDone)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: returns the nibble for whichever digit is selected
  assign displayNum = digit[0] ? tens : ones;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_seg"}, {1'b0, seg}, 8'h7F);
    check({tag, "_en"}, {6'd0, digitEn}, 8'h03);
    check({tag, "_digit"}, {6'd0, digit}, 8'h00);
    check({tag, "_done"}, {7'd0, frameDone}, 8'h00);
  endtask

  // k = edges since scanning started from IDLE; 12-cycle frame: 2 dark, 4 ones, 2 dark, 4 tens
  task automatic step(input int k, input logic [6:0] oseg, input logic [6:0] tseg,
                      input logic gate);
    int         p;
    logic       ph;
    logic [6:0] es;
    logic [1:0] ee;
    @(posedge clk);
    @(negedge clk);
    p  = (k - 1) % 12;
    ph = ((k >> 3) & 1) == 0;
    if (p >= 2 && p <= 5) begin
      ee = 2'b10; es = oseg;
    end else if (p >= 8) begin
      ee = 2'b01; es = tseg;
    end else begin
      ee = 2'b11; es = 7'h7F;
    end
    if (gate && !ph && ee != 2'b11) es = 7'h7F;
    check($sformatf("k%0d_seg", k), {1'b0, seg}, {1'b0, es});
    check($sformatf("k%0d_en", k), {6'd0, digitEn}, {6'd0, ee});
    check($sformatf("k%0d_digit", k), {6'd0, digit}, (p >= 6) ? 8'h01 : 8'h00);
    check($sformatf("k%0d_done", k), {7'd0, frameDone}, (p == 11) ? 8'h01 : 8'h00);
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_dark("rst_async");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_dark("rst_release");
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    blink  = 1'b0;
    ones   = 4'd7;
    tens   = 4'd4;
    repeat (2) @(negedge clk);
    check_dark("por");
    reset = 1'b0;

    // Run into ones SHOW, then reset mid-SHOW
    for (int k = 1; k <= 5; k++) step(k, 7'h78, 7'h19, 1'b0);
    restart();
    for (int k = 1; k <= 24; k++) step(k, 7'h78, 7'h19, 1'b0);

    // Score 5: tens zero suppressed but still enabled
    ones = 4'd5;
    tens = 4'd0;
    restart();
    for (int k = 1; k <= 12; k++) step(k, 7'h12, 7'h7F, 1'b0);

    // Blink on 88, then blink off
    ones  = 4'd8;
    tens  = 4'd8;
    blink = 1'b1;
    restart();
    for (int k = 1; k <= 32; k++) step(k, 7'h00, 7'h00, 1'b1);
    blink = 1'b0;
    for (int k = 33; k <= 44; k++) step(k, 7'h00, 7'h00, 1'b0);

    // Drop enable during tens SHOW, then restart scanning
    ones = 4'd7;
    tens = 4'd4;
    restart();
    for (int k = 1; k <= 9; k++) step(k, 7'h78, 7'h19, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_dark($sformatf("off%0d", i));
    end
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) step(k, 7'h78, 7'h19, 1'b0);

    // displayNum change mid ones SHOW only shows after the next latch
    ones = 4'd3;
    tens = 4'd4;
    restart();
    for (int k = 1; k <= 18; k++) begin
      step(k, (k < 12) ? 7'h30 : 7'h02, 7'h19, 1'b0);
      if (k == 4) ones = 4'd6;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_display_scan.md
Name: score_display_scan

Overview:
- Downstream consumer of the score BCD decoder.
- Time-multiplexes a 2-digit common-anode seven-segment display:
  - drives `digit` to the decoder;
  - samples the returned `displayNum` nibble;
  - encodes it to active-low segments;
  - asserts one active-low digit enable at a time.
- Inserts an anti-ghosting blank interval between digits, blanks a leading zero on the tens digit, and supports a blink mode for game-over/attract display.

Parameters:
- BLANK_CYCLES, default 500, clock cycles per blank interval (≥1); all digit enables off.
- SHOW_CYCLES, default 49500, clock cycles each digit is lit (≥1).
- BLINK_DIV, default 12500000, clock cycles per blink half-period (≥1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  1 = scan display; 0 = display dark, scanner idle
- blink  input  1  1 = gate segments with blink phase
- displayNum  input  4  BCD nibble from decoder for current `digit`
- digit  output  2  digit select to decoder: 0 = ones, 1 = tens; bit 1 always 0
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- digitEn  output  2  digit enables, active-low; bit 0 = ones, bit 1 = tens
- frameDone  output  1  one-cycle pulse at end of tens-digit SHOW

Behaviour:
- Reset (async, immediate): state = IDLE, digit = 0, seg = 7'h7F, digitEn = 2'b11, frameDone = 0, cycle counter = 0, blink counter = 0, blink phase = 1 (on), latched nibble = 0.
- All outputs are registered. No output depends combinationally on inputs.
- States and transitions:
  - IDLE: outputs dark. If enable = 1, go to BLANK next cycle with digit = 0 and counter = 0.
  - BLANK: digitEn = 2'b11, seg = 7'h7F. Lasts exactly BLANK_CYCLES cycles. On the last BLANK cycle, latch displayNum (decoder has ≥1 cycle of settled digit), then go to SHOW.
  - SHOW: digitEn asserts the bit for the current digit (digit 0 → 2'b10, digit 1 → 2'b01). seg = encode(latched nibble), subject to the blanking rules below. Lasts exactly SHOW_CYCLES cycles. On the last SHOW cycle: digit toggles 0↔1, counter clears, go to BLANK. If digit was 1, frameDone = 1 for that single cycle.
- enable = 0 in any state: next cycle state = IDLE, digit = 0, counters cleared, outputs dark. Blink counter holds.
- Leading-zero blanking: in SHOW with digit = 1 and latched nibble = 0, seg = 7'h7F. digitEn still asserts, so timing is unchanged.
- Blink:
  - The blink counter runs only while enable = 1. It toggles the phase after BLINK_DIV cycles and wraps to 0.
  - With blink = 1 and phase = 0, seg = 7'h7F in SHOW. With blink = 0, phase is ignored but keeps running.
- Encoding (seg, hex, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
  - Values >9 are not expected but are shown as hex.
- Frame period = 2 × (BLANK_CYCLES + SHOW_CYCLES) cycles.
- Never more than one digitEn bit low. Both bits are high throughout BLANK and IDLE.
- A displayNum change during BLANK (before the last cycle) or during SHOW has no effect until the next latch.

Test Plan (BLANK_CYCLES=2, SHOW_CYCLES=4, BLINK_DIV=8):
- Reset mid-SHOW, then release with enable=1 → outputs immediately dark (seg=7F, digitEn=11, digit=0). First SHOW starts 3 cycles after reset release (1 IDLE + 2 BLANK).
- Decoder model returning ones=7, tens=4 → repeating 12-cycle frame:
  - 2 cycles dark, 4 cycles digitEn=10/seg=78;
  - 2 cycles dark, 4 cycles digitEn=01/seg=19;
  - frameDone pulses exactly once per frame, on the last tens-SHOW cycle.
- Score 5 (ones=5, tens=0) → ones SHOW seg=12; tens SHOW digitEn=01 with seg=7F.
- blink=1 with ones=8, tens=8 → SHOW segments alternate between 00 and 7F on 8-cycle phase boundaries; digitEn timing unaffected. blink=0 → steady 00.
- Drop enable during tens SHOW → next cycle dark, digit=0. Re-raise enable → scan restarts with BLANK on digit 0.
- Change displayNum from 3 to 6 in the middle of ones SHOW → seg stays 30 until the next ones SHOW, which shows 02.
